// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks.
//   state_e    : control state of the windowed spike counters
//   DEF_CNT_W  : default per-channel spike counter width
//   DEF_WIN_W  : default window-length / sample-counter width
//   sat_inc    : saturating increment for counters up to 32 bits wide
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 8;

  // Increment val, clamping at the all-ones value of a width-bit counter.
  // The caller keeps the low width bits of the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational winner search over NUM_CH packed unsigned counts.
//   counts : channel k at bits [k*CNT_W +: CNT_W]
//   winner : index of the largest count, lowest index on a tie
//   tie    : the largest count is held by two or more channels
module spike_argmax #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH*CNT_W-1:0] counts,
  output logic [IDX_W-1:0]        winner,
  output logic                    tie
);

  logic [CNT_W-1:0] best;

  // Linear scan: a strictly larger count takes over and clears the tie
  // flag; an equal count keeps the earlier (lower) index and flags a tie.
  always_comb begin
    best   = counts[CNT_W-1:0];
    winner = '0;
    tie    = 1'b0;
    for (int k = 1; k < NUM_CH; k++) begin
      if (counts[k*CNT_W +: CNT_W] > best) begin
        best   = counts[k*CNT_W +: CNT_W];
        winner = IDX_W'(k);
        tie    = 1'b0;
      end else if (counts[k*CNT_W +: CNT_W] == best) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts spikes per channel over win_len valid
// samples (saturating), then presents the counts and winning channel on a
// valid/ready result interface.
//   clk, rst          : clock, synchronous active-high reset
//   en                : gates sampling and all state changes except the
//                       result handshake
//   start, win_len    : begin a window of win_len samples (IDLE only)
//   spike_valid/in    : one spike bit per channel per valid sample
//   busy              : window in progress or result pending
//   out_valid/ready   : result handshake
//   out_count         : channel k count at [k*CNT_W +: CNT_W]
//   out_winner/tie    : highest-count channel and shared-maximum flag
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    spike_valid,
  input  logic [NUM_CH-1:0]       spike_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_count,
  output logic [IDX_W-1:0]        out_winner,
  output logic                    out_tie
);

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [WIN_W-1:0]        smp_q, smp_d;
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH*CNT_W-1:0] out_count_q, out_count_d;
  logic [IDX_W-1:0]        out_winner_q, out_winner_d;
  logic                    out_tie_q, out_tie_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [IDX_W-1:0]        am_winner;
  logic                    am_tie;
  logic [31:0]             inc_w;

  spike_argmax #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .counts (cnt_q),
    .winner (am_winner),
    .tie    (am_tie)
  );

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    smp_d        = smp_q;
    cnt_d        = cnt_q;
    out_count_d  = out_count_q;
    out_winner_d = out_winner_q;
    out_tie_d    = out_tie_q;
    out_valid_d  = out_valid_q;
    inc_w        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (en && start && (win_len != '0)) begin
          win_d   = win_len;
          smp_d   = '0;
          cnt_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (en) begin
          // Once the window is full the counters are final; publish them
          // one edge later so the argmax works on registered counts.
          if (smp_q == win_q) begin
            out_count_d  = cnt_q;
            out_winner_d = am_winner;
            out_tie_d    = am_tie;
            out_valid_d  = 1'b1;
            state_d      = ST_HOLD;
          end else if (spike_valid) begin
            smp_d = smp_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              if (spike_in[k]) begin
                inc_w = sat_inc(32'(cnt_q[k*CNT_W +: CNT_W]), CNT_W);
                cnt_d[k*CNT_W +: CNT_W] = inc_w[CNT_W-1:0];
              end
            end
          end
        end
      end
      ST_HOLD: begin
        // Handshake is independent of en so a stalled sampler cannot
        // block the consumer.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      smp_q        <= '0;
      cnt_q        <= '0;
      out_count_q  <= '0;
      out_winner_q <= '0;
      out_tie_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      smp_q        <= smp_d;
      cnt_q        <= cnt_d;
      out_count_q  <= out_count_d;
      out_winner_q <= out_winner_d;
      out_tie_q    <= out_tie_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign out_winner = out_winner_q;
  assign out_tie    = out_tie_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (8-bit and 4-bit counters)
// share one stimulus stream and are checked every cycle against a
// behavioural model, with directed scenarios adding literal expectations.
module tb_spike_rate_decoder;

  localparam int NCH = 2;

  logic       clk = 1'b0;
  logic       rst, en, start, spike_valid, out_ready;
  logic [7:0] win_len;
  logic [1:0] spike_in;

  logic        busy8, vld8, wnr8, tie8;
  logic [15:0] cnt8;
  logic        busy4, vld4, wnr4, tie4;
  logic [7:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(2), .CNT_W(8), .WIN_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start), .win_len(win_len),
    .spike_valid(spike_valid), .spike_in(spike_in), .busy(busy8),
    .out_valid(vld8), .out_ready(out_ready), .out_count(cnt8),
    .out_winner(wnr8), .out_tie(tie8)
  );

  spike_rate_decoder #(.NUM_CH(2), .CNT_W(4), .WIN_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start), .win_len(win_len),
    .spike_valid(spike_valid), .spike_in(spike_in), .busy(busy4),
    .out_valid(vld4), .out_ready(out_ready), .out_count(cnt4),
    .out_winner(wnr4), .out_tie(tie4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for start, 1 collecting samples, 2 result offered
  int m_ph[2], m_n[2], m_win[2], m_vld[2], m_wnr[2], m_tie[2];
  int m_cnt[2][NCH];
  int m_res[2][NCH];
  int cap[2] = '{255, 15};

  task automatic model_step(input int i);
    int best, nbest;
    if (rst) begin
      m_ph[i] = 0; m_n[i] = 0; m_win[i] = 0; m_vld[i] = 0;
      m_wnr[i] = 0; m_tie[i] = 0;
      for (int k = 0; k < NCH; k++) begin m_cnt[i][k] = 0; m_res[i][k] = 0; end
    end else if (m_ph[i] == 0) begin
      if (en && start && win_len != 0) begin
        m_ph[i] = 1; m_win[i] = int'(win_len); m_n[i] = 0;
        for (int k = 0; k < NCH; k++) m_cnt[i][k] = 0;
      end
    end else if (m_ph[i] == 1) begin
      if (en) begin
        if (m_n[i] == m_win[i]) begin
          best = -1;
          for (int k = 0; k < NCH; k++)
            if (m_cnt[i][k] > best) begin best = m_cnt[i][k]; m_wnr[i] = k; end
          nbest = 0;
          for (int k = 0; k < NCH; k++) if (m_cnt[i][k] == best) nbest++;
          m_tie[i] = (nbest > 1) ? 1 : 0;
          for (int k = 0; k < NCH; k++) m_res[i][k] = m_cnt[i][k];
          m_vld[i] = 1; m_ph[i] = 2;
        end else if (spike_valid) begin
          m_n[i]++;
          for (int k = 0; k < NCH; k++)
            if (spike_in[k] && m_cnt[i][k] < cap[i]) m_cnt[i][k]++;
        end
      end
    end else begin
      if (out_ready) begin m_ph[i] = 0; m_vld[i] = 0; end
    end
  endtask

  task automatic cmp_inst(input int i, input string nm, input int b, input int v,
                          input int c0, input int c1, input int w, input int t);
    chk({nm, "_busy"}, b, (m_ph[i] != 0) ? 1 : 0);
    chk({nm, "_valid"}, v, m_vld[i]);
    chk({nm, "_count0"}, c0, m_res[i][0]);
    chk({nm, "_count1"}, c1, m_res[i][1]);
    chk({nm, "_winner"}, w, m_wnr[i]);
    chk({nm, "_tie"}, t, m_tie[i]);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    cmp_inst(0, "m8", int'(busy8), int'(vld8), int'(cnt8[7:0]), int'(cnt8[15:8]),
             int'(wnr8), int'(tie8));
    cmp_inst(1, "m4", int'(busy4), int'(vld4), int'(cnt4[3:0]), int'(cnt4[7:4]),
             int'(wnr4), int'(tie4));
  end

  // ---------------- directed helpers ----------------
  task automatic start_win(input int len);
    win_len = 8'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0; win_len = 8'd0;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n = 0;
    while (!vld8 && n < budget) begin @(negedge clk); n++; end
    if (!vld8) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_hs_valid"}, int'(vld8), 0);
    chk({nm, "_hs_busy"}, int'(busy8), 0);
  endtask

  task automatic sat_window(input string nm);
    start_win(255);
    spike_valid = 1'b1; spike_in = 2'b11;
    repeat (255) @(negedge clk);
    spike_valid = 1'b0; spike_in = 2'b00;
    wait_valid(nm, 5);
    chk({nm, "_c0_8"}, int'(cnt8[7:0]), 255);
    chk({nm, "_c1_8"}, int'(cnt8[15:8]), 255);
    chk({nm, "_tie8"}, int'(tie8), 1);
    chk({nm, "_wnr8"}, int'(wnr8), 0);
    chk({nm, "_c0_4"}, int'(cnt4[3:0]), 15);
    chk({nm, "_c1_4"}, int'(cnt4[7:4]), 15);
    chk({nm, "_tie4"}, int'(tie4), 1);
    handshake(nm);
  endtask

  logic [1:0] basic_pat [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
  logic       gap_v [7] = '{1, 0, 1, 1, 1, 0, 1};
  logic       gap_e [7] = '{1, 1, 0, 0, 1, 1, 1};
  logic [1:0] gap_s [7] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b10};

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; win_len = 8'd0;
    spike_valid = 1'b0; spike_in = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_valid", int'(vld8), 0);
    chk("rst_count", int'(cnt8), 0);
    chk("rst_winner", int'(wnr8), 0);
    chk("rst_tie", int'(tie8), 0);

    // Basic window of four samples.
    start_win(4);
    spike_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin spike_in = basic_pat[j]; @(negedge clk); end
    spike_valid = 1'b0; spike_in = 2'b00;
    chk("basic_lat_early", int'(vld8), 0);
    @(negedge clk);
    chk("basic_lat_valid", int'(vld8), 1);
    chk("basic_c0", int'(cnt8[7:0]), 3);
    chk("basic_c1", int'(cnt8[15:8]), 1);
    chk("basic_wnr", int'(wnr8), 0);
    chk("basic_tie", int'(tie8), 0);
    handshake("basic");

    // Gaps in spike_valid and en low mid-window.
    start_win(3);
    for (int j = 0; j < 7; j++) begin
      spike_valid = gap_v[j]; en = gap_e[j]; spike_in = gap_s[j];
      @(negedge clk);
    end
    spike_valid = 1'b0; en = 1'b1; spike_in = 2'b00;
    wait_valid("gap", 5);
    chk("gap_c0", int'(cnt8[7:0]), 0);
    chk("gap_c1", int'(cnt8[15:8]), 3);
    chk("gap_wnr", int'(wnr8), 1);
    chk("gap_tie", int'(tie8), 0);
    handshake("gap");

    // Saturation, twice in a row.
    sat_window("sat_a");
    sat_window("sat_b");

    // Backpressure in HOLD with start and spikes driven.
    start_win(2);
    spike_valid = 1'b1; spike_in = 2'b01;
    repeat (2) @(negedge clk);
    spike_valid = 1'b0;
    wait_valid("bp", 5);
    for (int j = 0; j < 10; j++) begin
      start = 1'b1; win_len = 8'd5; spike_valid = 1'b1; spike_in = 2'($urandom);
      @(negedge clk);
      chk("bp_valid", int'(vld8), 1);
      chk("bp_c0", int'(cnt8[7:0]), 2);
      chk("bp_c1", int'(cnt8[15:8]), 0);
    end
    spike_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("bp_idle_busy", int'(busy8), 0);
    chk("bp_idle_valid", int'(vld8), 0);
    chk("bp_idle_keep_c0", int'(cnt8[7:0]), 2);
    start_win(1);
    chk("bp_restart_busy", int'(busy8), 1);
    spike_valid = 1'b1; spike_in = 2'b10;
    @(negedge clk);
    spike_valid = 1'b0;
    wait_valid("bp2", 5);
    chk("bp2_c1", int'(cnt8[15:8]), 1);
    handshake("bp2");

    // Reset mid-window, then zero-length start.
    start_win(10);
    spike_valid = 1'b1; spike_in = 2'b11;
    repeat (3) @(negedge clk);
    spike_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_valid", int'(vld8), 0);
    chk("midrst_count", int'(cnt8), 0);
    start_win(0);
    chk("zero_busy", int'(busy8), 0);
    @(negedge clk);
    chk("zero_busy2", int'(busy8), 0);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom % 100);
      rst = ($urandom % 400) == 0;
      en = ($urandom % 8) != 0;
      start = ($urandom % 6) == 0;
      if (r < 10) win_len = 8'd0;
      else if (r < 20) win_len = 8'(20 + $urandom % 30);
      else win_len = 8'(1 + $urandom % 8);
      spike_valid = ($urandom % 4) != 0;
      spike_in = 2'($urandom);
      out_ready = ($urandom % 3) == 0;
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; spike_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Output-side counterpart of the threshold neuron array.
- Observes NUM_CH spike lines over a programmable window of valid samples and counts spikes per channel with saturation.
- Reports the per-channel counts and the winning channel through a valid/ready result handshake.
- Sits between the neuron outputs and the pin/readout logic; turns spike trains back into rate values.

Parameters:
NUM_CH, 2, number of spike channels observed
CNT_W, 8, width of each per-channel spike counter (saturating)
WIN_W, 8, width of the window-length input and the sample counter
IDX_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the winner index

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  global enable; when low, samples are ignored and the FSM holds
start  input  1  pulse: begin a new window (honoured only in IDLE)
win_len  input  WIN_W  window length in valid samples, sampled when start is accepted
spike_valid  input  1  spike_in carries a sample this cycle
spike_in  input  NUM_CH  one spike bit per channel
busy  output  1  high in COUNT and HOLD
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_count  output  NUM_CH*CNT_W  channel k count at bits [k*CNT_W +: CNT_W]
out_winner  output  IDX_W  channel index with the highest count
out_tie  output  1  the maximum count is shared by two or more channels

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; counters, sample counter, out_count, out_winner, out_tie, out_valid and busy all 0. Reset mid-window or mid-HOLD drops the result.
- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - start=1 and win_len!=0: latch win_len, clear all channel counters and the sample counter, go to COUNT.
  - start=1 with win_len==0: ignored, stay in IDLE.
- COUNT:
  - A sample is accepted when spike_valid && en.
  - On each accepted sample, every channel k with spike_in[k]=1 increments its counter, saturating at 2^CNT_W-1 (no wrap). The sample counter increments.
  - The sample that brings the sample counter to the latched win_len is included in the counts.
  - On the following edge: register out_count, out_winner and out_tie, set out_valid=1, go to HOLD.
  - Latency: out_valid rises exactly 1 cycle after the final accepted sample.
  - start during COUNT is ignored. Changing win_len during COUNT has no effect.
- HOLD:
  - out_valid stays 1 and result outputs stay stable until out_valid && out_ready at a clock edge.
  - On that edge go to IDLE; out_valid is 0 the next cycle.
  - start in the same cycle as the handshake, or anywhere in HOLD, is ignored; a new window needs start in IDLE.
  - Result outputs keep their last values in IDLE (not cleared).
  - Samples arriving in HOLD or IDLE are discarded.
- en=0: no sample accepted, no state change except reset. The handshake still completes in HOLD, because en only gates sampling.
- Winner rule: out_winner is the highest count; ties go to the lowest index, with out_tie=1. All counts zero gives winner 0 and out_tie=1 when NUM_CH>1. Comparison uses the saturated values.
- busy is a registered decode of state: 1 in COUNT and HOLD.

Decomposition:
- Shared package snn_pkg holds:
  - state enum typedef (IDLE, COUNT, HOLD)
  - default CNT_W and WIN_W constants
  - saturating-increment function, reused by future neuron/accumulator blocks
- One sub-module, spike_argmax: a combinational max/winner/tie tree over NUM_CH counts. Its output is registered by the parent when it enters HOLD.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 → busy=0, out_valid=0, out_count=0, out_winner=0, out_tie=0.
- Basic window: win_len=4, start; 4 valid samples spike_in=2'b01,2'b11,2'b01,2'b00 → out_valid 1 cycle after the 4th sample; count0=3, count1=1, winner=0, tie=0.
- Gaps and enable: win_len=3; spike_valid toggles and en=0 for 2 cycles mid-window; 3 accepted samples all 2'b10 → count1=3, count0=0, winner=1; samples during en=0 are not counted.
- Saturation: CNT_W=8, win_len=255 with spike_in=2'b11 every cycle, then a second window of win_len=255 after the handshake → counts 255 each; tie=1, winner=0. Repeat with CNT_W=4 → counts 15, no wrap.
- Backpressure: out_ready=0 for 10 cycles in HOLD, start pulsed and spikes driven → outputs stable, out_valid stays 1; out_ready=1 → IDLE next cycle, start then accepted.
- Reset mid-window and zero length: rst during COUNT → IDLE with out_valid=0; start with win_len=0 → stays IDLE, busy=0.
